clrfade: RTL and testbench

//  Bus-controlled colour sequencer that sits directly upstream of one colour-LED
//  PWM channel and drives its strobe/data write port.

---
 rtl/clrfade_if.sv | 22 ++
 rtl/clrfade.sv | 142 ++++++++++++++
 tb/tb_clrfade.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/clrfade_if.sv
// Bus and PWM-side signal bundle for the clrfade colour sequencer.
// The slave modport belongs to clrfade; the master modport belongs to the bus side.
interface clrfade_if;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic        i_wb_addr;
    logic [31:0] i_wb_data;
    logic [31:0] o_wb_data;
    logic        o_clr_stb;
    logic [31:0] o_clr_data;
    logic        o_busy;

    modport slave (
        input  i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        output o_wb_data, o_clr_stb, o_clr_data, o_busy
    );

    modport master (
        output i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        input  o_wb_data, o_clr_stb, o_clr_data, o_busy
    );
endinterface

// File: rtl/clrfade.sv
// Colour sequencer: steps a 3x9-bit colour toward a software target one LSB
// per channel per period tick and strobes each new colour into the PWM stage.
module clrfade #(
    parameter int                  LGPERIOD       = 24,
    parameter logic [LGPERIOD-1:0] DEFAULT_PERIOD = 24'd99_999,
    parameter logic [31:0]         INIT_CLR       = 32'h0003_0000
) (
    input  logic      i_clk,
    input  logic      i_reset,
    clrfade_if.slave  wb
);
    typedef enum logic [1:0] {S_SYNC, S_IDLE, S_FADE} state_t;

    // Internal colour layout is {R[8:0], G[8:0], B[8:0]}.
    function automatic logic [26:0] unpack_clr(input logic [31:0] d);
        return {d[26], d[23:16], d[25], d[15:8], d[24], d[7:0]};
    endfunction

    function automatic logic [31:0] pack_clr(input logic [26:0] c);
        return {5'b0, c[26], c[17], c[8], c[25:18], c[16:9], c[7:0]};
    endfunction

    function automatic logic [8:0] step_chan(input logic [8:0] c, input logic [8:0] t);
        if (c < t)
            return c + 9'd1;
        else if (c > t)
            return c - 9'd1;
        else
            return c;
    endfunction

    function automatic logic [26:0] step_clr(input logic [26:0] c, input logic [26:0] t);
        return {step_chan(c[26:18], t[26:18]), step_chan(c[17:9], t[17:9]),
                step_chan(c[8:0], t[8:0])};
    endfunction

    localparam logic [26:0] INIT_C = unpack_clr(INIT_CLR);

    state_t              r_state, w_state_nx;
    logic [26:0]         r_cur, w_cur_nx;
    logic [26:0]         r_tgt, w_tgt_nx;
    logic [LGPERIOD-1:0] r_period, w_period_nx;
    logic [LGPERIOD-1:0] r_pcnt, w_pcnt_nx;
    logic                r_clr_stb, w_stb_nx;
    logic [31:0]         r_clr_data, w_data_nx;
    logic                r_busy;
    logic [31:0]         r_wb_data, w_wb_data_nx;
    logic                w_wr_clr, w_wr_ctl;
    logic [26:0]         w_new_tgt, w_tick_clr;
    logic                w_unused;

    assign w_wr_clr   = wb.i_wb_stb & wb.i_wb_we & ~wb.i_wb_addr;
    assign w_wr_ctl   = wb.i_wb_stb & wb.i_wb_we &  wb.i_wb_addr;
    assign w_new_tgt  = unpack_clr(wb.i_wb_data);
    // A zero period at tick time means "finish now" rather than one more step.
    assign w_tick_clr = (r_period == '0) ? r_tgt : step_clr(r_cur, r_tgt);
    assign w_unused   = &{1'b0, wb.i_wb_data};

    assign w_period_nx  = w_wr_ctl ? wb.i_wb_data[LGPERIOD-1:0] : r_period;
    assign w_wb_data_nx = wb.i_wb_addr ? {r_busy, 7'h0, 24'(r_period)} : pack_clr(r_cur);

    always_comb begin
        w_state_nx = r_state;
        w_cur_nx   = r_cur;
        w_tgt_nx   = r_tgt;
        w_pcnt_nx  = r_pcnt;
        w_stb_nx   = 1'b0;
        w_data_nx  = r_clr_data;
        case (r_state)
            S_SYNC: begin
                w_stb_nx   = 1'b1;
                w_data_nx  = pack_clr(r_cur);
                w_state_nx = S_IDLE;
            end
            S_FADE: begin
                if (r_pcnt != '0) begin
                    w_pcnt_nx = r_pcnt - 1'b1;
                end else begin
                    w_cur_nx  = w_tick_clr;
                    w_stb_nx  = 1'b1;
                    w_data_nx = pack_clr(w_tick_clr);
                    w_pcnt_nx = r_period;
                    if (w_tick_clr == r_tgt)
                        w_state_nx = S_IDLE;
                end
            end
            default: ;
        endcase
        // A colour write overrides any tick on the same edge.
        if (w_wr_clr) begin
            w_tgt_nx = w_new_tgt;
            w_cur_nx = r_cur;
            if (r_state != S_SYNC) begin
                w_stb_nx  = 1'b0;
                w_data_nx = r_clr_data;
            end
            if (r_period == '0) begin
                w_cur_nx   = w_new_tgt;
                w_stb_nx   = 1'b1;
                w_data_nx  = pack_clr(w_new_tgt);
                w_state_nx = S_IDLE;
            end else if (w_new_tgt == r_cur) begin
                w_state_nx = S_IDLE;
            end else if (r_state == S_FADE) begin
                w_state_nx = S_FADE;
                w_pcnt_nx  = (r_pcnt != '0) ? r_pcnt - 1'b1 : r_pcnt;
            end else begin
                w_state_nx = S_FADE;
                w_pcnt_nx  = r_period;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_SYNC;
            r_cur      <= INIT_C;
            r_tgt      <= INIT_C;
            r_period   <= DEFAULT_PERIOD;
            r_pcnt     <= '0;
            r_clr_stb  <= 1'b0;
            r_clr_data <= INIT_CLR;
            r_busy     <= 1'b0;
            r_wb_data  <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_cur      <= w_cur_nx;
            r_tgt      <= w_tgt_nx;
            r_period   <= w_period_nx;
            r_pcnt     <= w_pcnt_nx;
            r_clr_stb  <= w_stb_nx;
            r_clr_data <= w_data_nx;
            r_busy     <= (w_state_nx == S_FADE);
            r_wb_data  <= w_wb_data_nx;
        end
    end

    assign wb.o_clr_stb  = r_clr_stb;
    assign wb.o_clr_data = r_clr_data;
    assign wb.o_busy     = r_busy;
    assign wb.o_wb_data  = r_wb_data;
endmodule

// File: tb/tb_clrfade.sv
// Directed bench for clrfade: reset/sync strobe, instant writes, fades,
// retargeting, mid-fade reset and period changes during a fade.
module tb_clrfade;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   n;
    bit   hit;

    clrfade_if bus ();

    clrfade dut (
        .i_clk   (clk),
        .i_reset (rst),
        .wb      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic a, input logic [31:0] d);
        @(negedge clk);
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_we   = 1'b1;
        bus.i_wb_addr = a;
        bus.i_wb_data = d;
        @(posedge clk);
        #1;
        bus.i_wb_stb = 1'b0;
        bus.i_wb_we  = 1'b0;
    endtask

    task automatic rd(input logic a);
        @(negedge clk);
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_we   = 1'b0;
        bus.i_wb_addr = a;
        @(posedge clk);
        #1;
        bus.i_wb_stb = 1'b0;
    endtask

    // Counts clock edges until a strobe is seen, up to maxc edges.
    task automatic wait_stb(input int maxc, output int cnt, output bit found);
        cnt   = 0;
        found = 1'b0;
        for (int i = 1; i <= maxc; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_clr_stb === 1'b1) begin
                cnt   = i;
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.i_wb_stb  = 1'b0;
        bus.i_wb_we   = 1'b0;
        bus.i_wb_addr = 1'b0;
        bus.i_wb_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        // T1: reset values and the single sync strobe
        chk("rst_clr_data", bus.o_clr_data, 32'h0003_0000);
        chk("rst_clr_stb", {31'b0, bus.o_clr_stb}, 32'h0);
        chk("rst_busy", {31'b0, bus.o_busy}, 32'h0);
        chk("rst_wb_data", bus.o_wb_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("sync_stb", {31'b0, bus.o_clr_stb}, 32'h1);
        chk("sync_data", bus.o_clr_data, 32'h0003_0000);
        @(posedge clk);
        #1;
        chk("sync_stb_once", {31'b0, bus.o_clr_stb}, 32'h0);

        // T2: period 0 gives an immediate jump
        wr(1'b1, 32'h0);
        wr(1'b0, 32'h07FF_FFFF);
        chk("p0_stb", {31'b0, bus.o_clr_stb}, 32'h1);
        chk("p0_data", bus.o_clr_data, 32'h07FF_FFFF);
        chk("p0_busy", {31'b0, bus.o_busy}, 32'h0);
        @(posedge clk);
        #1;
        chk("p0_stb_low", {31'b0, bus.o_clr_stb}, 32'h0);

        // T3: fade from 0x00030000 to 0x00000002, period 3
        wr(1'b0, 32'h0003_0000);
        wr(1'b1, 32'd3);
        wr(1'b0, 32'h0000_0002);
        chk("t3_busy_rise", {31'b0, bus.o_busy}, 32'h1);
        wait_stb(20, n, hit);
        chk("t3_s1_gap", n, 4);
        chk("t3_s1_data", bus.o_clr_data, 32'h0002_0001);
        wait_stb(20, n, hit);
        chk("t3_s2_gap", n, 4);
        chk("t3_s2_data", bus.o_clr_data, 32'h0001_0002);
        chk("t3_s2_busy", {31'b0, bus.o_busy}, 32'h1);
        wait_stb(20, n, hit);
        chk("t3_s3_gap", n, 4);
        chk("t3_s3_data", bus.o_clr_data, 32'h0000_0002);
        chk("t3_s3_busy", {31'b0, bus.o_busy}, 32'h0);
        rd(1'b0);
        chk("t3_rd_cur", bus.o_wb_data, 32'h0000_0002);

        // T4: retarget toward 0 after two steps
        wr(1'b1, 32'h0);
        wr(1'b0, 32'h0003_0000);
        wr(1'b1, 32'd3);
        wr(1'b0, 32'h0000_0005);
        wait_stb(20, n, hit);
        chk("t4_s1_data", bus.o_clr_data, 32'h0002_0001);
        wait_stb(20, n, hit);
        chk("t4_s2_data", bus.o_clr_data, 32'h0001_0002);
        wr(1'b0, 32'h0000_0000);
        wait_stb(20, n, hit);
        chk("t4_s3_hit", {31'b0, hit}, 32'h1);
        chk("t4_s3_data", bus.o_clr_data, 32'h0000_0001);
        wait_stb(20, n, hit);
        chk("t4_s4_data", bus.o_clr_data, 32'h0000_0000);
        chk("t4_s4_busy", {31'b0, bus.o_busy}, 32'h0);
        wait_stb(20, n, hit);
        chk("t4_idle", {31'b0, hit}, 32'h0);

        // T5: asynchronous reset in the middle of a fade
        wr(1'b0, 32'h0000_0003);
        wait_stb(20, n, hit);
        chk("t5_pre_data", bus.o_clr_data, 32'h0000_0001);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_async_data", bus.o_clr_data, 32'h0003_0000);
        chk("t5_async_busy", {31'b0, bus.o_busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_sync_stb", {31'b0, bus.o_clr_stb}, 32'h1);
        chk("t5_sync_data", bus.o_clr_data, 32'h0003_0000);
        rd(1'b1);
        chk("t5_rd_period", bus.o_wb_data, 32'h0001_869F);

        // T7: period set to 0 mid-fade finishes on the next tick
        wr(1'b1, 32'h0);
        wr(1'b0, 32'h0000_0000);
        wr(1'b1, 32'd3);
        wr(1'b0, 32'h0000_0010);
        wait_stb(20, n, hit);
        chk("t7_s1_data", bus.o_clr_data, 32'h0000_0001);
        wr(1'b1, 32'h0);
        wait_stb(20, n, hit);
        chk("t7_jump_data", bus.o_clr_data, 32'h0000_0010);
        chk("t7_jump_busy", {31'b0, bus.o_busy}, 32'h0);

        // T6: long period written mid-fade only applies at the next reload
        wr(1'b1, 32'd3);
        wr(1'b0, 32'h0000_0020);
        wait_stb(20, n, hit);
        chk("t6_s1_data", bus.o_clr_data, 32'h0000_0011);
        wr(1'b1, 32'h0012_3456);
        rd(1'b1);
        chk("t6_rd_ctrl", bus.o_wb_data, 32'h8012_3456);
        wait_stb(20, n, hit);
        chk("t6_s2_gap", n, 2);
        chk("t6_s2_data", bus.o_clr_data, 32'h0000_0012);
        wait_stb(50, n, hit);
        chk("t6_long_gap", {31'b0, hit}, 32'h0);
        rd(1'b0);
        chk("t6_rd_cur", bus.o_wb_data, 32'h0000_0012);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
